// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station schedulers: sizes, the
// "operand available" tag, the entry record and the ALU opcode set.
package rs_pkg;

  localparam int RS_SIZE = 16;
  localparam int IDX_W   = 4;
  localparam int ROB_W   = 4;
  localparam int OP_W    = 5;

  localparam logic [ROB_W-1:0] ROB_TAG_NONE = '0;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_op_e;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] rob_id;
  } rs_entry_t;

endpackage

// File: rtl/rs_issue_select.sv
// One-of-N issue picker shared by the ALU and LSB schedulers.
// Build option RS_AGE_PRIORITY_EN: oldest ready entry wins using an age
// matrix (age[i][j] set => entry i is older than entry j); otherwise the
// lowest-index ready entry wins.
module rs_issue_select
  import rs_pkg::*;
(
  input  logic [RS_SIZE-1:0]              ready,
`ifdef RS_AGE_PRIORITY_EN
  input  logic [RS_SIZE-1:0][RS_SIZE-1:0] age,
`endif
  output logic [RS_SIZE-1:0]              grant,
  output logic                            has_ready
);

  assign has_ready = |ready;

`ifdef RS_AGE_PRIORITY_EN
  // An entry wins when it is ready and no other ready entry is older than it
  always_comb begin
    logic blocked;
    grant   = '0;
    blocked = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && age[j][i]) blocked = 1'b1;
      end
      grant[i] = ready[i] && !blocked;
    end
  end
`else
  // Fixed priority: lowest-index ready entry wins
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rs_alu_scheduler.sv
// 16-entry integer ALU reservation station with CDB wakeup and a registered
// valid/ready issue port. Build option RS_AGE_PRIORITY_EN selects oldest-first
// issue instead of lowest-index-first.
module rs_alu_scheduler
  import rs_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid_in,
  input  logic [OP_W-1:0]  disp_op_in,
  input  logic [31:0]      disp_Vj_in,
  input  logic [31:0]      disp_Vk_in,
  input  logic [ROB_W-1:0] disp_Qj_in,
  input  logic [ROB_W-1:0] disp_Qk_in,
  input  logic [ROB_W-1:0] disp_rob_id_in,
  output logic             full_out,
  output logic             almost_full_out,
  input  logic             cdb_alu_valid_in,
  input  logic [ROB_W-1:0] cdb_alu_rob_id_in,
  input  logic [31:0]      cdb_alu_value_in,
  input  logic             cdb_mem_valid_in,
  input  logic [ROB_W-1:0] cdb_mem_rob_id_in,
  input  logic [31:0]      cdb_mem_value_in,
  output logic             alu_valid_out,
  input  logic             alu_ready_in,
  output logic [OP_W-1:0]  alu_op_out,
  output logic [31:0]      alu_a_out,
  output logic [31:0]      alu_b_out,
  output logic [ROB_W-1:0] alu_rob_id_out
);

  rs_entry_t          ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] vacant;
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] grant;
  logic               has_ready;
  logic               issue_open;
  logic               issue_fire;
  logic               disp_fire;
  logic [IDX_W-1:0]   alloc_idx;
  logic [OP_W-1:0]    sel_op;
  logic [31:0]        sel_vj;
  logic [31:0]        sel_vk;
  logic [ROB_W-1:0]   sel_rob;

  // A CDB broadcast matches a waiting operand; tag 0 never matches
  function automatic logic cdb_hit(input logic vld, input logic [ROB_W-1:0] tag,
                                   input logic [ROB_W-1:0] q);
    return vld && (tag != ROB_TAG_NONE) && (tag == q);
  endfunction

  // Operand value after snooping both CDBs; the ALU CDB wins a tie
  function automatic logic [31:0] snoop_v(input logic [ROB_W-1:0] q, input logic [31:0] v);
    if (cdb_hit(cdb_alu_valid_in, cdb_alu_rob_id_in, q)) return cdb_alu_value_in;
    if (cdb_hit(cdb_mem_valid_in, cdb_mem_rob_id_in, q)) return cdb_mem_value_in;
    return v;
  endfunction

  // Operand tag after snooping both CDBs
  function automatic logic [ROB_W-1:0] snoop_q(input logic [ROB_W-1:0] q);
    if (cdb_hit(cdb_alu_valid_in, cdb_alu_rob_id_in, q) ||
        cdb_hit(cdb_mem_valid_in, cdb_mem_rob_id_in, q)) return ROB_TAG_NONE;
    return q;
  endfunction

  // Busy and ready vectors from registered entry state
  always_comb begin
    busy  = '0;
    ready = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i]  = ent[i].busy;
      ready[i] = ent[i].busy && (ent[i].qj == ROB_TAG_NONE) && (ent[i].qk == ROB_TAG_NONE);
    end
  end

  assign vacant          = ~busy;
  assign full_out        = (vacant == '0);
  assign almost_full_out = (vacant != '0) && ((vacant & (vacant - 1'b1)) == '0);
  assign disp_fire       = disp_valid_in && !full_out;
  assign issue_open      = !alu_valid_out || alu_ready_in;
  assign issue_fire      = issue_open && has_ready;

  // Lowest-index vacant slot receives the next dispatch
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (vacant[i]) alloc_idx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age;

  // Age matrix: a new entry is younger than everything currently busy
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (flush_in) begin
      age <= '0;
    end else if (rdy_in && disp_fire) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) age[i][alloc_idx] <= 1'b1;
      end
      age[alloc_idx] <= '0;
    end
  end

  rs_issue_select u_select (
    .ready     (ready),
    .age       (age),
    .grant     (grant),
    .has_ready (has_ready)
  );
`else
  rs_issue_select u_select (
    .ready     (ready),
    .grant     (grant),
    .has_ready (has_ready)
  );
`endif

  // Mux the granted entry's payload toward the issue register
  always_comb begin
    sel_op  = '0;
    sel_vj  = '0;
    sel_vk  = '0;
    sel_rob = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        sel_op  = ent[i].op;
        sel_vj  = ent[i].vj;
        sel_vk  = ent[i].vk;
        sel_rob = ent[i].rob_id;
      end
    end
  end

  // Entry array: wakeup, release on issue, allocation with same-cycle CDB bypass
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent[i].busy) begin
          ent[i].qj <= snoop_q(ent[i].qj);
          ent[i].vj <= snoop_v(ent[i].qj, ent[i].vj);
          ent[i].qk <= snoop_q(ent[i].qk);
          ent[i].vk <= snoop_v(ent[i].qk, ent[i].vk);
        end
        if (issue_fire && grant[i]) ent[i].busy <= 1'b0;
      end
      if (disp_fire) begin
        ent[alloc_idx] <= '{busy:   1'b1,
                            op:     disp_op_in,
                            vj:     snoop_v(disp_Qj_in, disp_Vj_in),
                            vk:     snoop_v(disp_Qk_in, disp_Vk_in),
                            qj:     snoop_q(disp_Qj_in),
                            qk:     snoop_q(disp_Qk_in),
                            rob_id: disp_rob_id_in};
      end
    end
  end

  // Issue register: loads on an open slot, holds while the ALU stalls
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_out  <= 1'b0;
      alu_op_out     <= '0;
      alu_a_out      <= '0;
      alu_b_out      <= '0;
      alu_rob_id_out <= '0;
    end else if (flush_in) begin
      alu_valid_out <= 1'b0;
    end else if (rdy_in && issue_open) begin
      alu_valid_out <= has_ready;
      if (has_ready) begin
        alu_op_out     <= sel_op;
        alu_a_out      <= sel_vj;
        alu_b_out      <= sel_vk;
        alu_rob_id_out <= sel_rob;
      end
    end
  end

  // Decode must not dispatch into a full station
  assert property (@(posedge clk_in) disable iff (!rst_n)
    (rdy_in && !flush_in && disp_valid_in) |-> !full_out);

  // Both CDBs must never broadcast the same live tag together
  assert property (@(posedge clk_in) disable iff (!rst_n)
    (cdb_alu_valid_in && cdb_mem_valid_in && (cdb_alu_rob_id_in != ROB_TAG_NONE))
      |-> (cdb_alu_rob_id_in != cdb_mem_rob_id_in));

endmodule
